// File: rtl/riscv_i32_debug_fetch_ctrl_if.sv
// Bundle of host-command, result and fetch-debug request/response signals
// between the debug fetch controller (master) and its environment (slave).
interface riscv_i32_debug_fetch_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_error;
    logic [31:0] rsp_data;
    logic        halted;
    logic        debug_control__valid;
    logic        debug_control__kill_fetch;
    logic        debug_control__halt_request;
    logic        debug_control__fetch_dret;
    logic [31:0] debug_control__data;
    logic        debug_response__valid;
    logic        debug_response__kill_fetch;
    logic        debug_response__halt_request;
    logic        debug_response__fetch_dret;
    logic [31:0] debug_response__data;

    modport master (
        input  cmd_valid, cmd_op, cmd_data,
        input  debug_response__valid, debug_response__kill_fetch,
        input  debug_response__halt_request, debug_response__fetch_dret,
        input  debug_response__data,
        output cmd_ready, rsp_valid, rsp_error, rsp_data, halted,
        output debug_control__valid, debug_control__kill_fetch,
        output debug_control__halt_request, debug_control__fetch_dret,
        output debug_control__data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data,
        output debug_response__valid, debug_response__kill_fetch,
        output debug_response__halt_request, debug_response__fetch_dret,
        output debug_response__data,
        input  cmd_ready, rsp_valid, rsp_error, rsp_data, halted,
        input  debug_control__valid, debug_control__kill_fetch,
        input  debug_control__halt_request, debug_control__fetch_dret,
        input  debug_control__data
    );
endinterface

// File: rtl/riscv_i32_debug_fetch_ctrl.sv
// Debug-module initiator: turns single host commands into halt / inject / dret
// requests towards the fetch-debug stage, tracks halt state and times out requests.
module riscv_i32_debug_fetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1023
) (
    input  logic                                clk,
    input  logic                                reset,
    riscv_i32_debug_fetch_ctrl_if.master        ctrl_io
);
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    localparam logic [2:0] S_RUNNING    = 3'd0;
    localparam logic [2:0] S_HALTED     = 3'd1;
    localparam logic [2:0] S_HALT_REQ   = 3'd2;
    localparam logic [2:0] S_EXEC_REQ   = 3'd3;
    localparam logic [2:0] S_RESUME_REQ = 3'd4;

    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_RESUME = 2'd1;
    localparam logic [1:0] OP_EXEC   = 2'd2;
    localparam logic [1:0] OP_STATUS = 2'd3;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_error_q, rsp_error_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             dc_valid_q, dc_valid_d;
    logic             dc_kill_q, dc_kill_d;
    logic             dc_halt_q, dc_halt_d;
    logic             dc_dret_q, dc_dret_d;
    logic [31:0]      dc_data_q, dc_data_d;

    logic             cmd_ready_s;
    logic             accept_s;
    logic             resp_hit_s;
    logic [2:0]       succ_state_s;
    logic [2:0]       abort_state_s;
    logic             unused_s;

    assign cmd_ready_s = ((state_q == S_RUNNING) | (state_q == S_HALTED)) & ~rsp_valid_q;
    assign accept_s    = ctrl_io.cmd_valid & cmd_ready_s;
    assign unused_s    = ctrl_io.debug_response__kill_fetch;

    // Per transient state: which response completes it and where it lands on success or abort.
    always_comb begin
        resp_hit_s    = 1'b0;
        succ_state_s  = S_RUNNING;
        abort_state_s = S_RUNNING;
        case (state_q)
            S_HALT_REQ: begin
                resp_hit_s    = ctrl_io.debug_response__valid & ctrl_io.debug_response__halt_request;
                succ_state_s  = S_HALTED;
                abort_state_s = S_RUNNING;
            end
            S_EXEC_REQ: begin
                resp_hit_s    = ctrl_io.debug_response__valid;
                succ_state_s  = S_HALTED;
                abort_state_s = S_HALTED;
            end
            S_RESUME_REQ: begin
                resp_hit_s    = ctrl_io.debug_response__valid & ctrl_io.debug_response__fetch_dret;
                succ_state_s  = S_RUNNING;
                abort_state_s = S_HALTED;
            end
            default: begin
                resp_hit_s    = 1'b0;
                succ_state_s  = S_RUNNING;
                abort_state_s = S_RUNNING;
            end
        endcase
    end

    // Next-state, request and result computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halted_d    = halted_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        dc_valid_d  = dc_valid_q;
        dc_kill_d   = dc_kill_q;
        dc_halt_d   = dc_halt_q;
        dc_dret_d   = dc_dret_q;
        dc_data_d   = dc_data_q;
        case (state_q)
            S_RUNNING, S_HALTED: begin
                if (accept_s) begin
                    case (ctrl_io.cmd_op)
                        OP_HALT: begin
                            if (state_q == S_RUNNING) begin
                                state_d    = S_HALT_REQ;
                                cnt_d      = '0;
                                dc_valid_d = 1'b1;
                                dc_halt_d  = 1'b1;
                                dc_kill_d  = 1'b1;
                            end else begin
                                rsp_valid_d = 1'b1;
                            end
                        end
                        OP_RESUME: begin
                            if (state_q == S_HALTED) begin
                                state_d    = S_RESUME_REQ;
                                cnt_d      = '0;
                                dc_valid_d = 1'b1;
                                dc_dret_d  = 1'b1;
                            end else begin
                                rsp_valid_d = 1'b1;
                            end
                        end
                        OP_EXEC: begin
                            if (state_q == S_HALTED) begin
                                state_d    = S_EXEC_REQ;
                                cnt_d      = '0;
                                dc_valid_d = 1'b1;
                                dc_data_d  = ctrl_io.cmd_data;
                            end else begin
                                rsp_valid_d = 1'b1;
                                rsp_error_d = 1'b1;
                            end
                        end
                        OP_STATUS: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = {31'd0, halted_q};
                        end
                        default: begin
                            rsp_valid_d = 1'b0;
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            S_HALT_REQ, S_EXEC_REQ, S_RESUME_REQ: begin
                if (resp_hit_s) begin
                    state_d     = succ_state_s;
                    halted_d    = (succ_state_s == S_HALTED);
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    if (state_q == S_EXEC_REQ) begin
                        rsp_data_d = ctrl_io.debug_response__data;
                    end else begin
                        rsp_data_d = rsp_data_q;
                    end
                    dc_valid_d = 1'b0;
                    dc_kill_d  = 1'b0;
                    dc_halt_d  = 1'b0;
                    dc_dret_d  = 1'b0;
                    dc_data_d  = 32'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = abort_state_s;
                    halted_d    = (abort_state_s == S_HALTED);
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_data_d  = 32'd0;
                    dc_valid_d  = 1'b0;
                    dc_kill_d   = 1'b0;
                    dc_halt_d   = 1'b0;
                    dc_dret_d   = 1'b0;
                    dc_data_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: begin
                state_d    = S_RUNNING;
                halted_d   = 1'b0;
                cnt_d      = '0;
                dc_valid_d = 1'b0;
                dc_kill_d  = 1'b0;
                dc_halt_d  = 1'b0;
                dc_dret_d  = 1'b0;
                dc_data_d  = 32'd0;
            end
        endcase
    end

    // State and output registers; reset drops every request field at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RUNNING;
            cnt_q       <= '0;
            halted_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            dc_valid_q  <= 1'b0;
            dc_kill_q   <= 1'b0;
            dc_halt_q   <= 1'b0;
            dc_dret_q   <= 1'b0;
            dc_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halted_q    <= halted_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_data_q  <= rsp_data_d;
            dc_valid_q  <= dc_valid_d;
            dc_kill_q   <= dc_kill_d;
            dc_halt_q   <= dc_halt_d;
            dc_dret_q   <= dc_dret_d;
            dc_data_q   <= dc_data_d;
        end
    end

    assign ctrl_io.cmd_ready                   = cmd_ready_s;
    assign ctrl_io.rsp_valid                   = rsp_valid_q;
    assign ctrl_io.rsp_error                   = rsp_error_q;
    assign ctrl_io.rsp_data                    = rsp_data_q;
    assign ctrl_io.halted                      = halted_q;
    assign ctrl_io.debug_control__valid        = dc_valid_q;
    assign ctrl_io.debug_control__kill_fetch   = dc_kill_q;
    assign ctrl_io.debug_control__halt_request = dc_halt_q;
    assign ctrl_io.debug_control__fetch_dret   = dc_dret_q;
    assign ctrl_io.debug_control__data         = dc_data_q;
endmodule

// File: tb/tb_riscv_i32_debug_fetch_ctrl.sv
// Bench for riscv_i32_debug_fetch_ctrl: command table plus hand-built request
// sequences, with results checked against a scoreboard of expected responses.
module tb_riscv_i32_debug_fetch_ctrl;
    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_RESUME = 2'd1;
    localparam logic [1:0] OP_EXEC   = 2'd2;
    localparam logic [1:0] OP_STATUS = 2'd3;

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_data;
        logic        chk_data;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   dc_rose;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[7];

    riscv_i32_debug_fetch_ctrl_if bus();

    riscv_i32_debug_fetch_ctrl #(.TIMEOUT_CYCLES(32'd1023)) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic v, input logic k, input logic h, input logic d, input logic [31:0] data);
        bus.debug_response__valid        = v;
        bus.debug_response__kill_fetch   = k;
        bus.debug_response__halt_request = h;
        bus.debug_response__fetch_dret   = d;
        bus.debug_response__data         = data;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] d, input bit push, input exp_t e);
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_before_cmd", {31'd0, bus.cmd_ready}, 32'd1);
        if (push) sb_q.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 32'd0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("rsp_arrived", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    task automatic chk_ctrl(input string name, input logic v, input logic k, input logic h,
                            input logic d, input logic [31:0] data);
        chk({name, "_valid"}, {31'd0, bus.debug_control__valid}, {31'd0, v});
        chk({name, "_kill"}, {31'd0, bus.debug_control__kill_fetch}, {31'd0, k});
        chk({name, "_halt"}, {31'd0, bus.debug_control__halt_request}, {31'd0, h});
        chk({name, "_dret"}, {31'd0, bus.debug_control__fetch_dret}, {31'd0, d});
        chk({name, "_data"}, bus.debug_control__data, data);
    endtask

    task automatic do_halt();
        send(OP_HALT, 32'd0, 1'b1, '{1'b0, 32'd0, 1'b0});
        resp(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        wait_rsp();
    endtask

    task automatic do_resume();
        send(OP_RESUME, 32'd0, 1'b1, '{1'b0, 32'd0, 1'b0});
        resp(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        wait_rsp();
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            dc_rose = 1'b0;
            send(tbl[i].op, tbl[i].data, 1'b1, '{tbl[i].exp_err, tbl[i].exp_data, tbl[i].chk_data});
            wait_rsp();
            chk("no_request_for_immediate_cmd", {31'd0, dc_rose}, 32'd0);
        end
    endtask

    // Scoreboard: every result strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.debug_control__valid === 1'b1) dc_rose = 1'b1;
            if (bus.rsp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("rsp_error", {31'd0, bus.rsp_error}, {31'd0, mon_e.err});
                    if (mon_e.chk_data) chk("rsp_data", bus.rsp_data, mon_e.data);
                end
            end else if (bus.rsp_error !== 1'b0) begin
                chk("rsp_error_idle", {31'd0, bus.rsp_error}, 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int held_bad;
        checks = 0;
        errors = 0;
        dc_rose = 1'b0;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 32'd0;
        resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        tbl[0] = '{OP_STATUS, 32'd0,          1'b0, 32'd0, 1'b1};
        tbl[1] = '{OP_RESUME, 32'd0,          1'b0, 32'd0, 1'b0};
        tbl[2] = '{OP_EXEC,   32'h1234_5678,  1'b1, 32'd0, 1'b0};
        tbl[3] = '{OP_STATUS, 32'd0,          1'b0, 32'd0, 1'b1};
        tbl[4] = '{OP_STATUS, 32'd0,          1'b0, 32'd1, 1'b1};
        tbl[5] = '{OP_HALT,   32'd0,          1'b0, 32'd0, 1'b0};
        tbl[6] = '{OP_STATUS, 32'hFFFF_FFFF,  1'b0, 32'd1, 1'b1};

        tick();
        tick();
        chk("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
        chk("reset_rsp_data", bus.rsp_data, 32'd0);
        chk("reset_halted", {31'd0, bus.halted}, 32'd0);
        chk_ctrl("reset_ctrl", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        tick();

        run_table(0, 3);

        // Halt answered in the third cycle after the command.
        send(OP_HALT, 32'd0, 1'b1, '{1'b0, 32'd0, 1'b0});
        chk_ctrl("halt_c2", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        chk_ctrl("halt_c3", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        resp(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk_ctrl("halt_c4", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("halt_halted", {31'd0, bus.halted}, 32'd1);
        chk("halt_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("halt_ready_during_rsp", {31'd0, bus.cmd_ready}, 32'd0);
        tick();
        chk("halt_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
        wait_rsp();

        run_table(4, 6);

        // Instruction injection while halted.
        send(OP_EXEC, 32'h0010_2023, 1'b1, '{1'b0, 32'hDEAD_BEEF, 1'b1});
        chk_ctrl("exec_c2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0010_2023);
        tick();
        chk_ctrl("exec_c3", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0010_2023);
        resp(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        tick();
        resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk_ctrl("exec_c4", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("exec_halted", {31'd0, bus.halted}, 32'd1);
        wait_rsp();

        // Resume: a response with the wrong flag must be ignored.
        send(OP_RESUME, 32'd0, 1'b1, '{1'b0, 32'd0, 1'b0});
        chk_ctrl("resume_c2", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        resp(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        chk_ctrl("resume_ignored", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        resp(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk_ctrl("resume_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("resume_halted", {31'd0, bus.halted}, 32'd0);
        wait_rsp();

        // Halt: non-matching response ignored, matching one two cycles later completes.
        send(OP_HALT, 32'd0, 1'b1, '{1'b0, 32'd0, 1'b0});
        resp(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk_ctrl("halt_ignored", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("halt_ignored_halted", {31'd0, bus.halted}, 32'd0);
        tick();
        resp(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("halt_second_halted", {31'd0, bus.halted}, 32'd1);
        wait_rsp();
        do_resume();

        // Halt answered exactly on the timeout cycle: the response wins.
        send(OP_HALT, 32'd0, 1'b1, '{1'b0, 32'd0, 1'b0});
        held_bad = 0;
        for (int i = 0; i < 1022; i++) begin
            if (bus.debug_control__valid !== 1'b1) held_bad++;
            tick();
        end
        chk("edge_held_gaps", held_bad, 32'd0);
        chk("edge_last_cycle_valid", {31'd0, bus.debug_control__valid}, 32'd1);
        resp(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("edge_halted", {31'd0, bus.halted}, 32'd1);
        chk("edge_ctrl_dropped", {31'd0, bus.debug_control__valid}, 32'd0);
        wait_rsp();
        do_resume();

        // Halt with no response: aborts after the full timeout.
        send(OP_HALT, 32'd0, 1'b1, '{1'b1, 32'd0, 1'b1});
        n = 0;
        while (bus.debug_control__valid === 1'b1 && n < 1100) begin
            n++;
            tick();
        end
        chk("timeout_held_cycles", n, 32'd1023);
        chk("timeout_halted", {31'd0, bus.halted}, 32'd0);
        chk_ctrl("timeout_ctrl", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        wait_rsp();
        send(OP_EXEC, 32'hABCD_0001, 1'b1, '{1'b1, 32'd0, 1'b0});
        wait_rsp();
        send(OP_STATUS, 32'd0, 1'b1, '{1'b0, 32'd0, 1'b1});
        wait_rsp();

        // Reset while a resume request is outstanding.
        do_halt();
        send(OP_RESUME, 32'd0, 1'b0, '{1'b0, 32'd0, 1'b0});
        chk("pre_reset_dret", {31'd0, bus.debug_control__fetch_dret}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_ctrl("async_reset_ctrl", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("async_reset_halted", {31'd0, bus.halted}, 32'd0);
        chk("async_reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_ready", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        tick();
        chk("post_reset_no_rsp", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
